arcade_input_ctrl: RTL

Parametrised player-input front end for arcade cores: merges MiSTer joystick words and PS/2 key events for up to 4 players, applies screen-rotation remapping (0/90/180/270), generates timed coin pulses with an optional coin-on-start sequencer, and adds per-player autofire on button 0. Sits between `hps_io` and the game core, replacing ad-hoc keyboard decode and rotation muxing in each top level. All outputs are active-high; the core-side inverts as needed.

---
 rtl/arcade_input_pkg.sv | 103 ++++++++++
 rtl/arcade_coin_fsm.sv | 104 ++++++++++
 rtl/arcade_input_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared types, scan codes, key-state bit layout and helpers for the arcade input front end.
// Pure declarations: no latency, no backpressure.
package arcade_input_pkg;

  typedef enum logic [1:0] {ROT_0, ROT_CW, ROT_180, ROT_CCW} rot_e;
  typedef enum logic [1:0] {IDLE, COIN, GAP, START} coin_st_e;

  // Per-player key-state layout: [3:0] matches the joystick {up,down,left,right}
  localparam int          KS_W     = 10;
  localparam logic [3:0]  KS_RIGHT = 4'd0;
  localparam logic [3:0]  KS_LEFT  = 4'd1;
  localparam logic [3:0]  KS_DOWN  = 4'd2;
  localparam logic [3:0]  KS_UP    = 4'd3;
  localparam logic [3:0]  KS_BTN0  = 4'd4;
  localparam logic [3:0]  KS_BTN1  = 4'd5;
  localparam logic [3:0]  KS_BTN2  = 4'd6;
  localparam logic [3:0]  KS_BTN3  = 4'd7;
  localparam logic [3:0]  KS_START = 4'd8;
  localparam logic [3:0]  KS_COIN  = 4'd9;

  localparam logic [7:0] SC_P0_UP    = 8'h75;
  localparam logic [7:0] SC_P0_DOWN  = 8'h72;
  localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT = 8'h74;
  localparam logic [7:0] SC_P0_BTN0  = 8'h14;
  localparam logic [7:0] SC_P0_BTN1  = 8'h11;
  localparam logic [7:0] SC_P0_BTN2  = 8'h29;
  localparam logic [7:0] SC_P0_BTN3  = 8'h12;
  localparam logic [7:0] SC_P0_START = 8'h05;
  localparam logic [7:0] SC_P0_COIN  = 8'h2E;
  localparam logic [7:0] SC_P1_UP    = 8'h2D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h23;
  localparam logic [7:0] SC_P1_RIGHT = 8'h34;
  localparam logic [7:0] SC_P1_BTN0  = 8'h1C;
  localparam logic [7:0] SC_P1_BTN1  = 8'h1B;
  localparam logic [7:0] SC_P1_BTN2  = 8'h15;
  localparam logic [7:0] SC_P1_BTN3  = 8'h1D;
  localparam logic [7:0] SC_P1_START = 8'h06;
  localparam logic [7:0] SC_P1_COIN  = 8'h36;
  localparam logic [7:0] SC_P2_START = 8'h04;
  localparam logic [7:0] SC_P2_COIN  = 8'h3D;
  localparam logic [7:0] SC_P3_START = 8'h0C;
  localparam logic [7:0] SC_P3_COIN  = 8'h3E;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [3:0] bit_idx;
  } key_hit_t;

  function automatic key_hit_t map_key(input logic ext, input logic [7:0] code);
    key_hit_t k;
    k.hit     = 1'b1;
    k.player  = 2'd0;
    k.bit_idx = KS_UP;
    if (ext) begin
      case (code)
        SC_P0_UP:    k.bit_idx = KS_UP;
        SC_P0_DOWN:  k.bit_idx = KS_DOWN;
        SC_P0_LEFT:  k.bit_idx = KS_LEFT;
        SC_P0_RIGHT: k.bit_idx = KS_RIGHT;
        default:     k.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_P0_BTN0:  k.bit_idx = KS_BTN0;
        SC_P0_BTN1:  k.bit_idx = KS_BTN1;
        SC_P0_BTN2:  k.bit_idx = KS_BTN2;
        SC_P0_BTN3:  k.bit_idx = KS_BTN3;
        SC_P0_START: k.bit_idx = KS_START;
        SC_P0_COIN:  k.bit_idx = KS_COIN;
        SC_P1_UP:    begin k.player = 2'd1; k.bit_idx = KS_UP;    end
        SC_P1_DOWN:  begin k.player = 2'd1; k.bit_idx = KS_DOWN;  end
        SC_P1_LEFT:  begin k.player = 2'd1; k.bit_idx = KS_LEFT;  end
        SC_P1_RIGHT: begin k.player = 2'd1; k.bit_idx = KS_RIGHT; end
        SC_P1_BTN0:  begin k.player = 2'd1; k.bit_idx = KS_BTN0;  end
        SC_P1_BTN1:  begin k.player = 2'd1; k.bit_idx = KS_BTN1;  end
        SC_P1_BTN2:  begin k.player = 2'd1; k.bit_idx = KS_BTN2;  end
        SC_P1_BTN3:  begin k.player = 2'd1; k.bit_idx = KS_BTN3;  end
        SC_P1_START: begin k.player = 2'd1; k.bit_idx = KS_START; end
        SC_P1_COIN:  begin k.player = 2'd1; k.bit_idx = KS_COIN;  end
        SC_P2_START: begin k.player = 2'd2; k.bit_idx = KS_START; end
        SC_P2_COIN:  begin k.player = 2'd2; k.bit_idx = KS_COIN;  end
        SC_P3_START: begin k.player = 2'd3; k.bit_idx = KS_START; end
        SC_P3_COIN:  begin k.player = 2'd3; k.bit_idx = KS_COIN;  end
        default:     k.hit = 1'b0;
      endcase
    end
    return k;
  endfunction

  // d and result are {up,down,left,right}
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    case (r)
      ROT_CW:  return {d[1], d[0], d[2], d[3]};
      ROT_180: return {d[2], d[3], d[0], d[1]};
      ROT_CCW: return {d[0], d[1], d[3], d[2]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/arcade_coin_fsm.sv
// Per-player coin pulse / coin-on-start sequencer; raw coin edge to p_coin in 2 cycles.
// Edges arriving outside IDLE are dropped, nothing queues; outputs registered.
module arcade_coin_fsm
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES  = 600000,
  parameter int START_CYCLES = 600000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic primed,
  input  logic coin_on_start,
  input  logic raw_coin,
  input  logic raw_start,
  output logic p_coin,
  output logic p_start
);

  localparam int MAX_CYCLES = (COIN_CYCLES > START_CYCLES) ? COIN_CYCLES : START_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);

  coin_st_e      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          seq, seq_n;
  logic          coin_hist, start_hist, coin_rise, start_rise;

  // History loads even on the un-primed cycle so a held input cannot fire after reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_hist  <= 1'b0;
      start_hist <= 1'b0;
      coin_rise  <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      coin_hist  <= raw_coin;
      start_hist <= raw_start;
      coin_rise  <= primed & raw_coin & ~coin_hist;
      start_rise <= primed & raw_start & ~start_hist;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seq_n   = seq;
    case (state)
      IDLE: begin
        if (coin_rise) begin
          state_n = COIN;
          cnt_n   = '0;
          seq_n   = 1'b0;
        end else if (coin_on_start && start_rise) begin
          state_n = COIN;
          cnt_n   = '0;
          seq_n   = 1'b1;
        end
      end
      COIN: begin
        if (cnt == COIN_LAST) begin
          state_n = seq ? GAP : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == COIN_LAST) begin
          state_n = START;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      START: begin
        if (cnt < START_LAST) cnt_n = cnt + 1'b1;
        if (cnt >= START_LAST && !raw_start) begin
          state_n = IDLE;
          cnt_n   = '0;
          seq_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      seq     <= 1'b0;
      p_coin  <= 1'b0;
      p_start <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      seq     <= seq_n;
      p_coin  <= (state_n == COIN);
      p_start <= (state_n == START) | (~coin_on_start & raw_start);
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 keys and joysticks per player, rotates directions, autofires button 0, times coins.
// Joystick->out 1 cycle, PS/2 event->out 2 cycles; no backpressure, all outputs registered.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 4,
  parameter int COIN_CYCLES  = 600000,
  parameter int START_CYCLES = 600000,
  parameter int AF_PERIOD    = 400000
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joystick,
  input  logic [1:0]                   rotate,
  input  logic [PLAYERS-1:0]           autofire_en,
  input  logic                         coin_on_start,
  output logic [4*PLAYERS-1:0]         p_dir,
  output logic [BUTTONS*PLAYERS-1:0]   p_btn,
  output logic [PLAYERS-1:0]           p_start,
  output logic [PLAYERS-1:0]           p_coin
);

  localparam int AFW = $clog2(AF_PERIOD) + 1;
  localparam logic [AFW-1:0] AF_LAST = AFW'(AF_PERIOD - 1);

  logic            tog_q, primed, key_evt;
  key_hit_t        hit;
  logic [KS_W-1:0] key_state [PLAYERS];
  logic [AFW-1:0]  af_cnt;
  logic            af_phase;

  // Joystick bits above the configured buttons are not consumed
  logic unused_joy;
  assign unused_joy = ^joystick;

  assign key_evt = primed && (ps2_key[10] != tog_q);
  assign hit     = map_key(ps2_key[8], ps2_key[7:0]);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q  <= 1'b0;
      primed <= 1'b0;
    end else begin
      tog_q  <= ps2_key[10];
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) key_state[p] <= '0;
    end else if (key_evt && hit.hit) begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (hit.player == 2'(p)) key_state[p][hit.bit_idx] <= ps2_key[9];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]         raw_dir, dir_q;
    logic [BUTTONS-1:0] raw_btn, btn_n, btn_q;

    assign raw_dir = key_state[p][3:0] | joystick[16*p +: 4];

    for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
      if (b < 4) begin : g_key
        assign raw_btn[b] = key_state[p][KS_BTN0 + b] | joystick[16*p + 4 + b];
      end else begin : g_joy
        assign raw_btn[b] = joystick[16*p + 4 + b];
      end
    end

    always_comb begin
      btn_n    = raw_btn;
      btn_n[0] = raw_btn[0] & (autofire_en[p] ? af_phase : 1'b1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        dir_q <= '0;
        btn_q <= '0;
      end else begin
        dir_q <= rotate_dir(raw_dir, rot_e'(rotate));
        btn_q <= btn_n;
      end
    end

    assign p_dir[4*p +: 4]             = dir_q;
    assign p_btn[BUTTONS*p +: BUTTONS] = btn_q;

    arcade_coin_fsm #(
      .COIN_CYCLES  (COIN_CYCLES),
      .START_CYCLES (START_CYCLES)
    ) u_coin (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .primed        (primed),
      .coin_on_start (coin_on_start),
      .raw_coin      (key_state[p][KS_COIN]),
      .raw_start     (key_state[p][KS_START]),
      .p_coin        (p_coin[p]),
      .p_start       (p_start[p])
    );
  end

endmodule
